// File: rtl/bus_pkg.sv
// Shared bus code package.
// Holds the source/destination code numbering used by both the bus
// multiplexer (SEL_*) and the destination register file (DST_*), so the
// two sides always agree on which code names which register.
// No ports.
package bus_pkg;

  localparam int unsigned DATA_W = 32;

  // Destination codes (write side)
  localparam logic [7:0] DST_DRAM = 8'd0;
  localparam logic [7:0] DST_IRAM = 8'd1;  // read-only, never writable
  localparam logic [7:0] DST_DI   = 8'd2;
  localparam logic [7:0] DST_RI   = 8'd3;
  localparam logic [7:0] DST_BI   = 8'd4;
  localparam logic [7:0] DST_S    = 8'd5;
  localparam logic [7:0] DST_C1   = 8'd6;
  localparam logic [7:0] DST_C2   = 8'd7;
  localparam logic [7:0] DST_AR   = 8'd8;
  localparam logic [7:0] DST_AC   = 8'd9;
  localparam logic [7:0] DST_PC   = 8'd10;
  localparam logic [7:0] DST_IR   = 8'd11;
  localparam logic [7:0] DST_NONE = 8'd255;

  // Source codes (read side), same numbering
  localparam logic [7:0] SEL_DRAM = 8'd0;
  localparam logic [7:0] SEL_IRAM = 8'd1;
  localparam logic [7:0] SEL_DI   = 8'd2;
  localparam logic [7:0] SEL_RI   = 8'd3;
  localparam logic [7:0] SEL_BI   = 8'd4;
  localparam logic [7:0] SEL_S    = 8'd5;
  localparam logic [7:0] SEL_C1   = 8'd6;
  localparam logic [7:0] SEL_C2   = 8'd7;
  localparam logic [7:0] SEL_AR   = 8'd8;
  localparam logic [7:0] SEL_AC   = 8'd9;
  localparam logic [7:0] SEL_PC   = 8'd10;
  localparam logic [7:0] SEL_IR   = 8'd11;

  // True for codes the register file accepts: DRAM, any register, or NONE.
  function automatic logic dest_is_legal(input logic [7:0] code);
    return (code == DST_DRAM) || ((code >= DST_DI) && (code <= DST_IR)) ||
           (code == DST_NONE);
  endfunction

endpackage

// File: rtl/bus_counter_reg.sv
// Loadable counter register with zero flag.
// A bus load has priority over the count step. Arithmetic wraps modulo
// 2^WIDTH. zero is combinational from the current value.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (value -> RESET_VAL)
//   load, load_val synchronous load from the bus
//   step           increment (DECREMENT = 0) or decrement (DECREMENT = 1)
//   q              register value
//   zero           q == 0
module bus_counter_reg #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              DECREMENT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      q_d = DECREMENT ? (q - WIDTH'(1)) : (q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_d;
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/bus_dest_regfile.sv
// Destination register file: write side of the datapath bus.
// Loads the shared bus into the architectural register selected by dest,
// issues a one-cycle registered data-RAM write strobe for DST_DRAM, and
// performs the PC increment, C1/C2 decrement and ALU->AC side operations.
// A bus load always wins over a side operation on the same register.
// Optional build macro BUS_DEST_ERR_EN adds a sticky dest_err output that
// flags illegal destination codes (1 and 12..254).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   dest, bus           destination code and bus data
//   pc_inc, c1_dec, c2_dec, alu_we, alu_result   side operations
//   DI..IR              register contents
//   c1_zero, c2_zero    counter zero flags
//   dram_we, dram_addr, dram_wdata   data-RAM write port
//   dest_err            (BUS_DEST_ERR_EN only) sticky illegal-code flag
module bus_dest_regfile import bus_pkg::*; #(
  parameter int unsigned        DATA_W   = bus_pkg::DATA_W,
  parameter int unsigned        DRAM_W   = 8,
  parameter int unsigned        DRAM_AW  = 8,
  parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        dest,
  input  logic [DATA_W-1:0] bus,
  input  logic              pc_inc,
  input  logic              c1_dec,
  input  logic              c2_dec,
  input  logic              alu_we,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] RI,
  output logic [DATA_W-1:0] BI,
  output logic [DATA_W-1:0] S,
  output logic [DATA_W-1:0] C1,
  output logic [DATA_W-1:0] C2,
  output logic [DATA_W-1:0] AR,
  output logic [DATA_W-1:0] AC,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic              c1_zero,
  output logic              c2_zero,
  output logic              dram_we,
  output logic [DRAM_AW-1:0] dram_addr,
`ifdef BUS_DEST_ERR_EN
  output logic              dest_err,
`endif
  output logic [DRAM_W-1:0] dram_wdata
);

  logic ld_di, ld_ri, ld_bi, ld_s, ld_c1, ld_c2, ld_ar, ld_ac, ld_pc, ld_ir;
  logic ld_dram;

  always_comb begin
    ld_dram = (dest == DST_DRAM);
    ld_di   = (dest == DST_DI);
    ld_ri   = (dest == DST_RI);
    ld_bi   = (dest == DST_BI);
    ld_s    = (dest == DST_S);
    ld_c1   = (dest == DST_C1);
    ld_c2   = (dest == DST_C2);
    ld_ar   = (dest == DST_AR);
    ld_ac   = (dest == DST_AC);
    ld_pc   = (dest == DST_PC);
    ld_ir   = (dest == DST_IR);
  end

  // Plain bus-loaded registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DI <= '0;
      RI <= '0;
      BI <= '0;
      S  <= '0;
      AR <= '0;
      IR <= '0;
    end else begin
      if (ld_di) DI <= bus;
      if (ld_ri) RI <= bus;
      if (ld_bi) BI <= bus;
      if (ld_s)  S  <= bus;
      if (ld_ar) AR <= bus;
      if (ld_ir) IR <= bus;
    end
  end

  // AC: bus load beats the ALU result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AC <= '0;
    end else if (ld_ac) begin
      AC <= bus;
    end else if (alu_we) begin
      AC <= alu_result;
    end
  end

  logic pc_zero_unused;

  bus_counter_reg #(
    .WIDTH     (DATA_W),
    .RESET_VAL (PC_RESET),
    .DECREMENT (1'b0)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld_pc),
    .load_val (bus),
    .step     (pc_inc),
    .q        (PC),
    .zero     (pc_zero_unused)
  );

  bus_counter_reg #(
    .WIDTH     (DATA_W),
    .RESET_VAL ('0),
    .DECREMENT (1'b1)
  ) u_c1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld_c1),
    .load_val (bus),
    .step     (c1_dec),
    .q        (C1),
    .zero     (c1_zero)
  );

  bus_counter_reg #(
    .WIDTH     (DATA_W),
    .RESET_VAL ('0),
    .DECREMENT (1'b1)
  ) u_c2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld_c2),
    .load_val (bus),
    .step     (c2_dec),
    .q        (C2),
    .zero     (c2_zero)
  );

  // DRAM write strobe: address/data captured with the pre-edge AR and bus,
  // and held while the strobe is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
    end else begin
      dram_we <= ld_dram;
      if (ld_dram) begin
        dram_addr  <= AR[DRAM_AW-1:0];
        dram_wdata <= bus[DRAM_W-1:0];
      end
    end
  end

`ifdef BUS_DEST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_err <= 1'b0;
    end else if (!dest_is_legal(dest)) begin
      dest_err <= 1'b1;
    end
  end
`endif

endmodule
